// File: rtl/vend_pkg.sv
// Shared types for the vending dispenser: FSM states, result-event encoding
// and the LOAD-state dispatch helper.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DROP  = 3'd2,
    EJ5   = 3'd3,
    EJ10  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int EV_SUC = 2;
  localparam int EV_R5  = 1;
  localparam int EV_R10 = 0;

  typedef logic [2:0] evt_t;

  // Drink first, then small change, then large change.
  function automatic state_t first_dest(input evt_t e);
    state_t s;
    if (e[EV_SUC]) begin
      s = DROP;
    end else if (e[EV_R5]) begin
      s = EJ5;
    end else if (e[EV_R10]) begin
      s = EJ10;
    end else begin
      s = IDLE;
    end
    return s;
  endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// Result/actuator bundle between the vending controller, the dispenser and
// the mechanical actuators.
interface vend_dispenser_if #(
  parameter int DEPTH = 4
) ();
  logic                     suc;
  logic                     rest_5;
  logic                     rest_10;
  logic                     drop_can;
  logic                     can_done;
  logic                     eject_5;
  logic                     eject_10;
  logic                     coin_ack;
  logic                     busy;
  logic [$clog2(DEPTH):0]   pending;
  logic                     overflow;
  logic                     fault;
  logic                     clr_fault;

  modport master (
    output suc, rest_5, rest_10, can_done, coin_ack, clr_fault,
    input  drop_can, eject_5, eject_10, busy, pending, overflow, fault
  );

  modport slave (
    input  suc, rest_5, rest_10, can_done, coin_ack, clr_fault,
    output drop_can, eject_5, eject_10, busy, pending, overflow, fault
  );
endinterface

// File: rtl/vend_evt_fifo.sv
// DEPTH x 3 event FIFO. A push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module vend_evt_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  evt_t                   wdata,
  output evt_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_nxt
);
  localparam int AW = $clog2(DEPTH);

  evt_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_n;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign count_nxt = count_n;

  // Occupancy for the next cycle.
  always_comb begin
    count_n = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_n = count_r + (AW+1)'(1'b1);
      2'b01:   count_n = count_r - (AW+1)'(1'b1);
      default: count_n = count_r;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      count_r <= count_n;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
    end
  end

  // Entry storage; validity is tracked by the occupancy count alone.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Dispenser back end: queues controller result pulses and drives the can and
// coin actuators one at a time with acknowledge, timeout and sticky faults.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 10
) (
  input logic             clk,
  input logic             reset,
  vend_dispenser_if.slave bus
);
  localparam int PW = $clog2(DEPTH) + 1;

  state_t        state_r;
  state_t        state_n;
  evt_t          cur_r;
  evt_t          cur_n;
  evt_t          evt_s;
  evt_t          head_s;
  logic [CW-1:0] timer_r;
  logic [CW-1:0] timer_n;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          ovf_s;
  logic          fault_set_s;
  logic          tmo_s;
  logic [PW-1:0] count_s;
  logic [PW-1:0] count_nxt_s;
  logic          drop_can_r;
  logic          eject_5_r;
  logic          eject_10_r;
  logic          busy_r;
  logic          overflow_r;
  logic          fault_r;

  assign evt_s  = {bus.suc, bus.rest_5, bus.rest_10};
  assign push_s = |evt_s;
  assign pop_s  = (state_r == IDLE) && !empty_s;
  assign ovf_s  = push_s && full_s && !pop_s;
  // The edge that ends this cycle is the one where the timer reaches TIMEOUT.
  assign tmo_s  = (timer_r == CW'(TIMEOUT - 1));

  vend_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .wdata     (evt_s),
    .rdata     (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s),
    .count_nxt (count_nxt_s)
  );

  // Next-state, working-event and timer logic.
  always_comb begin
    state_n     = state_r;
    cur_n       = cur_r;
    timer_n     = timer_r;
    fault_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          cur_n   = head_s;
          state_n = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        timer_n = {CW{1'b0}};
        state_n = first_dest(cur_r);
      end
      DROP, EJ5, EJ10: begin
        timer_n = timer_r + CW'(1'b1);
        if ((state_r == DROP) ? bus.can_done : bus.coin_ack) begin
          case (state_r)
            DROP:    cur_n[EV_SUC] = 1'b0;
            EJ5:     cur_n[EV_R5]  = 1'b0;
            default: cur_n[EV_R10] = 1'b0;
          endcase
          state_n = LOAD;
        end else if (tmo_s) begin
          state_n     = FAULT;
          fault_set_s = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      FAULT: begin
        if (bus.clr_fault) begin
          cur_n   = 3'b000;
          state_n = IDLE;
        end else begin
          state_n = FAULT;
        end
      end
      default: begin
        cur_n   = 3'b000;
        state_n = IDLE;
      end
    endcase
  end

  // State, actuator and status registers; actuators decode the next state so
  // each rises together with its state and stays one-hot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cur_r      <= 3'b000;
      timer_r    <= {CW{1'b0}};
      drop_can_r <= 1'b0;
      eject_5_r  <= 1'b0;
      eject_10_r <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      cur_r      <= cur_n;
      timer_r    <= timer_n;
      drop_can_r <= (state_n == DROP);
      eject_5_r  <= (state_n == EJ5);
      eject_10_r <= (state_n == EJ10);
      busy_r     <= (state_n != IDLE) || (count_nxt_s != {PW{1'b0}});
      if (ovf_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clr_fault) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (fault_set_s) begin
        fault_r <= 1'b1;
      end else if (bus.clr_fault) begin
        fault_r <= 1'b0;
      end else begin
        fault_r <= fault_r;
      end
    end
  end

  assign bus.drop_can = drop_can_r;
  assign bus.eject_5  = eject_5_r;
  assign bus.eject_10 = eject_10_r;
  assign bus.busy     = busy_r;
  assign bus.pending  = count_s;
  assign bus.overflow = overflow_r;
  assign bus.fault    = fault_r;

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream end of the drink vending controller's result interface.
- Consumes the controller's one-cycle result pulses: suc (deliver drink), rest_5 (return a 5 coin), rest_10 (return a 10 coin).
- Buffers each result as an event in a small FIFO, then drives the can-drop and coin-hopper actuators one at a time, with done/ack handshakes, timeout and fault reporting.

Parameters:
- DEPTH, 4, event FIFO entries; power of two, minimum 2.
- TIMEOUT, 1000, maximum cycles an actuator may stay asserted without its acknowledge; minimum 2.
- CW, 10, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- suc  in  1  one-cycle pulse: deliver one drink.
- rest_5  in  1  one-cycle pulse: return one 5 coin.
- rest_10  in  1  one-cycle pulse: return one 10 coin.
- drop_can  out  1  can-drop actuator request; level, held until can_done.
- can_done  in  1  can actuator completion; sampled only in DROP.
- eject_5  out  1  5-coin hopper request; level.
- eject_10  out  1  10-coin hopper request; level.
- coin_ack  in  1  hopper completion; sampled only in EJ5/EJ10.
- busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.
- pending  out  $clog2(DEPTH)+1  number of FIFO entries.
- overflow  out  1  sticky: an event was lost because the FIFO was full.
- fault  out  1  sticky: an actuator timed out.
- clr_fault  in  1  clears fault and overflow and releases FAULT.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, pending=0, FSM=IDLE, timer=0.
- All outputs at reset: drop_can=0, eject_5=0, eject_10=0, busy=0, overflow=0, fault=0.
- Event capture:
  - Any cycle where {suc,rest_5,rest_10} != 0 pushes the 3-bit vector as one entry.
  - An all-zero vector is never pushed.
  - Pushing is allowed in every FSM state, FAULT included.
- Full FIFO:
  - A push with no same-cycle pop is discarded and sets overflow.
  - A push coinciding with a pop is accepted; pending is unchanged.
- Empty FIFO: no pop occurs.
- Same-cycle push into an empty FIFO: the entry is visible to the FSM on the next cycle, not the same cycle.
- Pointer arithmetic: pointers wrap modulo DEPTH; pending ranges 0..DEPTH.
- FSM states: IDLE, LOAD, DROP, EJ5, EJ10, FAULT.
  - IDLE: if the FIFO is not empty, pop the head into the 3-bit register cur and go to LOAD.
  - LOAD (one cycle): go to the first set bit of cur in the order suc -> DROP, rest_5 -> EJ5, rest_10 -> EJ10.
  - DROP: drop_can=1. On can_done, clear cur.suc and return to LOAD.
  - EJ5: eject_5=1. On coin_ack, clear cur.r5 and return to LOAD.
  - EJ10: eject_10=1. On coin_ack, clear cur.r10 and return to LOAD.
  - LOAD with cur==0 goes to IDLE.
  - FAULT: all actuator outputs are 0. Leave to IDLE on clr_fault=1, discarding cur. FIFO contents are retained.
- Actuator outputs are registered and one-hot: at most one is high in any cycle. Each rises the cycle after entering its state.
- Timeout:
  - The timer clears on entry to DROP/EJ5/EJ10 and increments every cycle in those states.
  - If the timer reaches TIMEOUT with no acknowledge: go to FAULT and set fault=1.
  - An acknowledge in the same cycle the timer reaches TIMEOUT counts as success.
- clr_fault:
  - Clears both sticky flags in any state.
  - If a new overflow occurs in the same cycle, overflow stays set.
- Acknowledges are ignored in states that do not sample them.
- busy = (state != IDLE) || (pending != 0).
- Reset mid-operation drops all actuator outputs asynchronously; queued events are lost.

Decomposition:
- Shared package vend_pkg holds:
  - state enum (IDLE, LOAD, DROP, EJ5, EJ10, FAULT);
  - event bit indices EV_SUC=2, EV_R5=1, EV_R10=0;
  - the 3-bit event typedef.
- One sub-module, vend_evt_fifo: parameterised DEPTH×3 synchronous FIFO with push, pop, full, empty and count.
- The FSM, timer and sticky flags stay in vend_dispenser.

Test Plan:
- Single drink: suc pulse -> drop_can rises 3 cycles later. can_done held 1 cycle after 5 cycles high -> drop_can falls, busy=0 two cycles later.
- Drink plus change: one cycle with suc=1 and rest_5=1 -> DROP, then EJ5 in sequence. Never both actuators high. pending returns 0.
- Burst: 6 consecutive rest_10 pulses, DEPTH=4, coin_ack tied 0 -> first event popped, 4 queued, 6th discarded -> pending=4, overflow=1.
- Timeout: suc with can_done never asserted -> drop_can high for TIMEOUT cycles, then 0. fault=1, FSM=FAULT. clr_fault -> fault=0, next queued event processed.
- Boundary ack: coin_ack arrives in the same cycle the timer hits TIMEOUT -> no fault, eject ends normally.
- Async reset mid-DROP: reset=0 asynchronously -> drop_can=0 immediately, pending=0. After release, ignores a stale can_done.
